cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter for the Tomasulo core. It collects finished results from NUM_FU functional units and buffers each unit's results in a per-channel FIFO. Each cycle it grants exactly one result onto a registered CDB (RS tag, data, pc) that drives the RS and register-file update ports. It generalises the fixed 5-FU done_record delay scheme with configurable channel count, buffer depth, priority mode, backpressure and flush.

---
 rtl/cdb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU result FIFOs feeding a single registered CDB broadcast.
// Fixed-priority or round-robin selection, with FIFO bypass when the winning channel is empty.
module cdb_arbiter #(
    parameter int unsigned NUM_FU    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    input  logic [NUM_FU*32-1:0]       fu_pc,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_rs_num,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [31:0]                cdb_pc,
    output logic [NUM_FU-1:0]          cdb_grant
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(NUM_FU);
    localparam int          NF = int'(NUM_FU);

    logic [TAG_W-1:0]  tag_q  [NUM_FU][DEPTH];
    logic [TAG_W-1:0]  tag_d  [NUM_FU][DEPTH];
    logic [DATA_W-1:0] data_q [NUM_FU][DEPTH];
    logic [DATA_W-1:0] data_d [NUM_FU][DEPTH];
    logic [31:0]       pc_q   [NUM_FU][DEPTH];
    logic [31:0]       pc_d   [NUM_FU][DEPTH];
    logic [PW-1:0]     rd_q   [NUM_FU];
    logic [PW-1:0]     rd_d   [NUM_FU];
    logic [PW-1:0]     wr_q   [NUM_FU];
    logic [PW-1:0]     wr_d   [NUM_FU];
    logic [CW-1:0]     cnt_q  [NUM_FU];
    logic [CW-1:0]     cnt_d  [NUM_FU];
    logic [WW-1:0]     rr_q, rr_d;

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  rs_q, rs_d;
    logic [DATA_W-1:0] cdata_q, cdata_d;
    logic [31:0]       cpc_q, cpc_d;
    logic [NUM_FU-1:0] grant_q, grant_d;

    logic [NUM_FU-1:0] acc;
    logic [NUM_FU-1:0] req;
    logic              any_req;
    logic [WW-1:0]     win;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on the registered count, never on a same-cycle pop.
    always_comb begin
        fu_ready = '0;
        acc      = '0;
        req      = '0;
        for (int i = 0; i < NF; i++) begin
            fu_ready[i] = (cnt_q[i] < CW'(DEPTH));
            acc[i]      = fu_valid[i] & fu_ready[i];
            req[i]      = (cnt_q[i] != '0) | acc[i];
        end
    end

    // Descending scans leave the highest-priority requester as the final assignment.
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        any_req = |req;
        if (PRIO_MODE == 0) begin
            for (int i = NF - 1; i >= 0; i--) begin
                if (req[i]) win = WW'(i);
            end
        end else begin
            for (int k = NF; k >= 1; k--) begin
                idx = (int'(rr_q) + k) % NF;
                if (req[idx]) win = WW'(idx);
            end
        end
    end

    always_comb begin
        logic push;
        logic pop;
        tag_d   = tag_q;
        data_d  = data_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        valid_d = 1'b0;
        rs_d    = '0;
        cdata_d = cdata_q;
        cpc_d   = cpc_q;
        grant_d = '0;
        push    = 1'b0;
        pop     = 1'b0;
        if (flush) begin
            for (int i = 0; i < NF; i++) begin
                cnt_d[i] = '0;
                rd_d[i]  = '0;
                wr_d[i]  = '0;
            end
            rr_d = WW'(NUM_FU - 1);
        end else begin
            for (int i = 0; i < NF; i++) begin
                // A winner with an empty FIFO takes its input straight to the CDB instead.
                push = acc[i] & ~(any_req && (win == WW'(i)) && (cnt_q[i] == '0));
                pop  = any_req && (win == WW'(i)) && (cnt_q[i] != '0);
                if (push) begin
                    tag_d[i][wr_q[i]]  = fu_tag[i*TAG_W +: TAG_W];
                    data_d[i][wr_q[i]] = fu_data[i*DATA_W +: DATA_W];
                    pc_d[i][wr_q[i]]   = fu_pc[i*32 +: 32];
                    wr_d[i]            = ptr_inc(wr_q[i]);
                end
                if (pop) begin
                    rd_d[i] = ptr_inc(rd_q[i]);
                end
                cnt_d[i] = cnt_q[i] + CW'(push) - CW'(pop);
            end
            if (any_req) begin
                valid_d      = 1'b1;
                grant_d[win] = 1'b1;
                rr_d         = win;
                if (cnt_q[win] != '0) begin
                    rs_d    = tag_q[win][rd_q[win]];
                    cdata_d = data_q[win][rd_q[win]];
                    cpc_d   = pc_q[win][rd_q[win]];
                end else begin
                    rs_d    = fu_tag[int'(win)*TAG_W +: TAG_W];
                    cdata_d = fu_data[int'(win)*DATA_W +: DATA_W];
                    cpc_d   = fu_pc[int'(win)*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NF; i++) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    tag_q[i][j]  <= '0;
                    data_q[i][j] <= '0;
                    pc_q[i][j]   <= '0;
                end
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q    <= WW'(NUM_FU - 1);
            valid_q <= 1'b0;
            rs_q    <= '0;
            cdata_q <= '0;
            cpc_q   <= '0;
            grant_q <= '0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            cdata_q <= cdata_d;
            cpc_q   <= cpc_d;
            grant_q <= grant_d;
        end
    end

    assign cdb_valid  = valid_q;
    assign cdb_rs_num = rs_q;
    assign cdb_data   = cdata_q;
    assign cdb_pc     = cpc_q;
    assign cdb_grant  = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: fixed-priority and round-robin instances share stimulus and are
// checked against a queue-based reference model, plus directed vectors and corner sequences.
module tb_cdb_arbiter;

    localparam int NUM_FU = 5;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 8;
    localparam int DEPTH  = 2;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU*32-1:0]     fu_pc;

    logic [NUM_FU-1:0] f_ready, r_ready, f_grant, r_grant;
    logic              f_valid, r_valid;
    logic [TAG_W-1:0]  f_rs, r_rs;
    logic [DATA_W-1:0] f_data, r_data;
    logic [31:0]       f_pc, r_pc;

    cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
                  .PRIO_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_data(fu_data), .fu_pc(fu_pc), .fu_ready(f_ready), .cdb_valid(f_valid),
        .cdb_rs_num(f_rs), .cdb_data(f_data), .cdb_pc(f_pc), .cdb_grant(f_grant)
    );

    cdb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
                  .PRIO_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_data(fu_data), .fu_pc(fu_pc), .fu_ready(r_ready), .cdb_valid(r_valid),
        .cdb_rs_num(r_rs), .cdb_data(r_data), .cdb_pc(r_pc), .cdb_grant(r_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int viol_fix = 0;

    // Protocol monitor: valid presented to the fixed-priority instance while it is not ready.
    always @(posedge clk) begin
        if (rst && !flush && ((fu_valid & ~f_ready) != '0)) viol_fix <= viol_fix + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
    } ent_t;

    ent_t              mq [2*NUM_FU][$];
    logic              m_v     [2];
    logic [TAG_W-1:0]  m_tag   [2];
    logic [DATA_W-1:0] m_data  [2];
    logic [31:0]       m_pc    [2];
    logic [NUM_FU-1:0] m_grant [2];
    int                m_ptr   [2];

    function automatic ent_t in_ent(input int i);
        ent_t e;
        e.tag  = fu_tag[i*TAG_W +: TAG_W];
        e.data = fu_data[i*DATA_W +: DATA_W];
        e.pc   = fu_pc[i*32 +: 32];
        return e;
    endfunction

    function automatic logic [NUM_FU-1:0] exp_ready(input int m);
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = (mq[m*NUM_FU+i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NUM_FU; i++) mq[m*NUM_FU+i].delete();
            m_v[m] = 1'b0; m_tag[m] = '0; m_data[m] = '0; m_pc[m] = '0;
            m_grant[m] = '0; m_ptr[m] = NUM_FU - 1;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic [NUM_FU-1:0] acc;
            int w;
            int idx;
            ent_t e;
            if (flush) begin
                for (int i = 0; i < NUM_FU; i++) mq[m*NUM_FU+i].delete();
                m_v[m] = 1'b0; m_tag[m] = '0; m_grant[m] = '0; m_ptr[m] = NUM_FU - 1;
            end else begin
                acc = '0;
                for (int i = 0; i < NUM_FU; i++)
                    acc[i] = fu_valid[i] && (mq[m*NUM_FU+i].size() < DEPTH);
                w = -1;
                for (int k = 0; k < NUM_FU; k++) begin
                    idx = (m == 0) ? k : (m_ptr[m] + 1 + k) % NUM_FU;
                    if (w < 0 && (acc[idx] || mq[m*NUM_FU+idx].size() > 0)) w = idx;
                end
                if (w >= 0) begin
                    if (mq[m*NUM_FU+w].size() > 0) begin
                        e = mq[m*NUM_FU+w].pop_front();
                        if (acc[w]) mq[m*NUM_FU+w].push_back(in_ent(w));
                    end else begin
                        e = in_ent(w);
                    end
                    m_v[m] = 1'b1; m_tag[m] = e.tag; m_data[m] = e.data; m_pc[m] = e.pc;
                    m_grant[m] = NUM_FU'(1) << w;
                    m_ptr[m] = w;
                end else begin
                    m_v[m] = 1'b0; m_tag[m] = '0; m_grant[m] = '0;
                end
                for (int i = 0; i < NUM_FU; i++)
                    if (i != w && acc[i]) mq[m*NUM_FU+i].push_back(in_ent(i));
            end
        end
    endtask

    task automatic check_model();
        chk("fix.valid", f_valid, m_v[0]);
        chk("fix.rs_num", f_rs, m_tag[0]);
        chk("fix.grant", f_grant, m_grant[0]);
        chk("fix.ready", f_ready, exp_ready(0));
        if (m_v[0]) begin
            chk("fix.data", f_data, m_data[0]);
            chk("fix.pc", f_pc, m_pc[0]);
        end
        chk("rr.valid", r_valid, m_v[1]);
        chk("rr.rs_num", r_rs, m_tag[1]);
        chk("rr.grant", r_grant, m_grant[1]);
        chk("rr.ready", r_ready, exp_ready(1));
        if (m_v[1]) begin
            chk("rr.data", r_data, m_data[1]);
            chk("rr.pc", r_pc, m_pc[1]);
        end
    endtask

    // Inputs change only at posedge+1 or later; outputs are sampled at posedge+1.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst.fix_valid", f_valid, 1'b0);
        chk("rst.fix_grant", f_grant, '0);
        chk("rst.fix_rs", f_rs, '0);
        chk("rst.rr_valid", r_valid, 1'b0);
        chk("rst.fix_ready", f_ready, 5'b11111);
        #2;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [NUM_FU-1:0]       vld;
        logic [NUM_FU*TAG_W-1:0] tag;
        logic [DATA_W-1:0]       data;
        logic                    ev;
        logic [TAG_W-1:0]        etag;
        logic [DATA_W-1:0]       edata;
        logic [NUM_FU-1:0]       egrant;
        logic [NUM_FU-1:0]       erdy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        rst = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0; fu_pc = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed vectors, expectations for the fixed-priority instance.
        vecs[0] = '{5'b00100, 40'h00_00_13_00_00, 32'hDEADBEEF, 1'b1, 8'h13, 32'hDEADBEEF,
                    5'b00100, 5'b11111};
        vecs[1] = '{5'b00000, 40'h0, 32'h0, 1'b0, 8'h00, 32'h0, 5'b00000, 5'b11111};
        vecs[2] = '{5'b01011, 40'h00_03_00_02_01, 32'h1111, 1'b1, 8'h01, 32'h1111,
                    5'b00001, 5'b11111};
        vecs[3] = '{5'b00000, 40'h0, 32'h0, 1'b1, 8'h02, 32'h1111, 5'b00010, 5'b11111};
        vecs[4] = '{5'b00000, 40'h0, 32'h0, 1'b1, 8'h03, 32'h1111, 5'b01000, 5'b11111};
        vecs[5] = '{5'b00000, 40'h0, 32'h0, 1'b0, 8'h00, 32'h0, 5'b00000, 5'b11111};
        for (int v = 0; v < 6; v++) begin
            fu_valid = vecs[v].vld;
            fu_tag   = vecs[v].tag;
            fu_data  = {NUM_FU{vecs[v].data}};
            for (int i = 0; i < NUM_FU; i++) fu_pc[i*32 +: 32] = $urandom;
            step();
            chk($sformatf("vec%0d.valid", v), f_valid, vecs[v].ev);
            chk($sformatf("vec%0d.rs_num", v), f_rs, vecs[v].etag);
            chk($sformatf("vec%0d.grant", v), f_grant, vecs[v].egrant);
            chk($sformatf("vec%0d.ready", v), f_ready, vecs[v].erdy);
            if (vecs[v].ev) chk($sformatf("vec%0d.data", v), f_data, vecs[v].edata);
        end

        // Round-robin fairness: channels 0 and 4 present whenever the RR instance is ready.
        idle_inputs();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            fu_valid = {r_ready[4], 3'b000, r_ready[0]};
            fu_tag[0 +: TAG_W]       = TAG_W'(8'h10 + c);
            fu_tag[4*TAG_W +: TAG_W] = TAG_W'(8'h40 + c);
            fu_data = {NUM_FU{32'(c)}};
            step();
            chk($sformatf("rr.alt%0d", c), r_grant, (c % 2 == 0) ? 5'b00001 : 5'b10000);
        end

        // Backpressure on channel 1 under fixed priority.
        idle_inputs();
        do_reset();
        begin
            int v0;
            v0 = viol_fix;
            for (int c = 0; c < 6; c++) begin
                fu_valid = (c < 4) ? 5'b00011 : 5'b00000;
                fu_tag[0 +: TAG_W]     = TAG_W'(8'h50 + c);
                fu_tag[TAG_W +: TAG_W] = TAG_W'(c + 1);
                if (c == 2) chk("bp.ready1_low", f_ready[1], 1'b0);
                step();
                if (c < 4) begin
                    chk($sformatf("bp.ch0_%0d", c), f_rs, TAG_W'(8'h50 + c));
                    chk($sformatf("bp.gnt_%0d", c), f_grant, 5'b00001);
                end else begin
                    chk($sformatf("bp.drain_%0d", c), f_rs, TAG_W'(c - 3));
                    chk($sformatf("bp.dgnt_%0d", c), f_grant, 5'b00010);
                end
            end
            idle_inputs();
            step();
            chk("bp.idle", f_valid, 1'b0);
            chk("bp.violations", viol_fix - v0, 2);
        end

        // Flush discards buffered results.
        do_reset();
        fu_valid = 5'b01111;
        fu_tag   = 40'h00_A3_A2_A1_A0;
        step();
        chk("fl.first", f_rs, 8'hA0);
        fu_valid = '0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("fl.fix_valid", f_valid, 1'b0);
        chk("fl.rr_valid", r_valid, 1'b0);
        chk("fl.fix_ready", f_ready, 5'b11111);
        chk("fl.rr_ready", r_ready, 5'b11111);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("fl.stale_fix%0d", c), f_valid, 1'b0);
            chk($sformatf("fl.stale_rr%0d", c), r_valid, 1'b0);
        end

        // Asynchronous reset while FIFOs hold results.
        do_reset();
        fu_valid = 5'b01111;
        fu_tag   = 40'h00_B3_B2_B1_B0;
        step();
        fu_valid = '0;
        step();
        chk("ar.pre_valid", f_valid, 1'b1);
        chk("ar.pre_rs", f_rs, 8'hB1);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("ar.fix_valid", f_valid, 1'b0);
        chk("ar.fix_grant", f_grant, '0);
        chk("ar.fix_rs", f_rs, '0);
        chk("ar.rr_valid", r_valid, 1'b0);
        chk("ar.rr_grant", r_grant, '0);
        #1;
        rst = 1'b1;
        fu_valid = 5'b01000;
        fu_tag   = 40'h00_77_00_00_00;
        fu_data  = {NUM_FU{32'h12345678}};
        step();
        chk("ar.byp_valid", f_valid, 1'b1);
        chk("ar.byp_rs", f_rs, 8'h77);
        chk("ar.byp_grant", f_grant, 5'b01000);
        chk("ar.byp_data", f_data, 32'h12345678);
        fu_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("ar.no_stale%0d", c), f_valid, 1'b0);
        end

        // Randomized traffic with occasional flush.
        for (int c = 0; c < 400; c++) begin
            fu_valid = NUM_FU'($urandom);
            for (int i = 0; i < NUM_FU; i++) begin
                fu_tag[i*TAG_W +: TAG_W]   = TAG_W'($urandom);
                fu_data[i*DATA_W +: DATA_W] = $urandom;
                fu_pc[i*32 +: 32]          = $urandom;
            end
            flush = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();
        for (int c = 0; c < 12; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
